w_sched_ctrl: RTL and testbench
===============================

// Module: w_sched_ctrl
// PURPOSE
// Sequences one 512-bit padded block through the SHA-256 W message-schedule generator.
// Accepts a block from the padding stage and holds it on pad_reg. Drives the generator's
// go/read/address handshake for W[0..NUM_W-1] and forwards each W word to the compression
// round engine over a valid/ready stream. Sits between the padder and the round datapath.
// PARAMETERS
// NUM_W    64   words fetched per block; must be <= 64 (6-bit index)
// RD_LAT   2    cycles from the w_read cycle to w_data valid; range 1..7
// TO_MAX   255  max cycles waiting on w_rdy edge before timeout; range 1..255
// PORTS
// clock        in   1    single clock; all state changes on rising edge
// reset        in   1    asynchronous, active-low reset
// blk_valid    in   1    padded block offered
// blk_ready    out  1    block accepted when blk_valid & blk_ready
// blk_data     in   512  padded block, W[0] in [511:480]
// pad_reg      out  512  latched block to generator
// w_go         out  1    generator go (local_go_sig)
// w_read       out  1    generator read strobe, one-cycle pulse
// w_addr       out  6    generator word address
// w_rdy        in   1    generator ready
// w_data       in   32   generator W output
// w_valid      out  1    W word to round engine valid
// w_ready      in   1    round engine accepts
// w_out        out  32   W word
// w_idx        out  6    index of w_out
// w_last       out  1    w_out is word NUM_W-1
// busy         out  1    state != IDLE
// done         out  1    one-cycle pulse, block fully sequenced
// timeout_err  out  1    sticky, w_rdy wait exceeded TO_MAX; cleared on next block accept
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; all outputs 0 except blk_ready=1; counters 0.
// - FSM states: IDLE, ARM, REQ, WAIT, OUT, RELEASE.
// - IDLE: blk_ready=1. On blk_valid: latch blk_data->pad_reg, idx<=0, clear timeout_err, ->ARM.
// - ARM: w_go=1. Stay until w_rdy=1, then ->REQ. TO counter increments each ARM cycle;
//   at TO_MAX with w_rdy=0: set timeout_err, ->RELEASE.
// - REQ: exactly one cycle. w_read=1, w_addr=idx, then ->WAIT with latency counter=RD_LAT.
// - WAIT: w_read=0, w_addr held. Decrement latency counter each cycle. On the edge ending
//   the RD_LAT-th cycle after REQ: w_out<=w_data, w_idx<=idx, w_last<=(idx==NUM_W-1), ->OUT.
// - OUT: w_valid=1. w_out, w_idx and w_last stay stable until w_ready=1.
//   On transfer: if w_last, ->RELEASE; else idx<=idx+1, ->REQ. w_valid drops the next cycle.
// - Only one generator read is outstanding at any time. Peak rate is one W per RD_LAT+2 cycles.
// - RELEASE: w_go=0. Wait for w_rdy=0, with the same TO_MAX limit; on timeout set
//   timeout_err and leave anyway. On leaving: ->IDLE; done=1 only if timeout_err is clear.
// - w_go=1 in ARM, REQ, WAIT and OUT. It drops in RELEASE so the generator returns to idle.
// - pad_reg changes only on a block accept in IDLE. blk_ready=0 in every state except IDLE.
// - idx arithmetic: 6-bit. idx never exceeds NUM_W-1, so no wrap occurs within a block.
// - busy=1 in every state except IDLE. done is never asserted together with blk_ready.
// - Reset during any state aborts immediately. No partial word is emitted after reset release.
// TESTING
// - Reset: hold reset=0 and toggle inputs -> blk_ready=1; w_go, w_read, w_valid, done,
//   timeout_err, busy all 0.
// - Full block, w_ready tied 1, generator model with RD_LAT=2 -> 64 words with w_idx 0..63
//   in order; w_last only at idx 63; w_read exactly 64 pulses with w_addr=0..63;
//   done one pulse; w_go falls in RELEASE.
// - Backpressure: w_ready=0 for 5 cycles at idx 10 -> w_out and w_idx=10 stable;
//   no w_read pulse during the stall; idx 11 is requested on the cycle after the transfer.
// - Timeout: w_rdy stuck 0 -> timeout_err=1 after 255 ARM cycles; state returns to IDLE;
//   no done pulse; the next block accept clears timeout_err.
// - Reset mid-run at idx 30 -> all outputs at reset values on the next cycle. The next block
//   restarts at w_addr=0.
// - Back-to-back blocks, blk_valid held 1 -> second accept only after RELEASE sees w_rdy=0.
//   The second block's pad_reg value appears only on that accept.

Source files
------------

// File: rtl/w_sched_ctrl.sv
// Sequences one padded 512-bit block through the SHA-256 W schedule generator
// and streams W[0..NUM_W-1] to the round engine, one outstanding read at a time.
module w_sched_ctrl #(
  parameter int NUM_W  = 64,
  parameter int RD_LAT = 2,
  parameter int TO_MAX = 255
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [511:0] i_blk_data,
  output logic [511:0] o_pad_reg,
  output logic         o_w_go,
  output logic         o_w_read,
  output logic [5:0]   o_w_addr,
  input  logic         i_w_rdy,
  input  logic [31:0]  i_w_data,
  output logic         o_w_valid,
  input  logic         i_w_ready,
  output logic [31:0]  o_w_out,
  output logic [5:0]   o_w_idx,
  output logic         o_w_last,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_timeout_err
);

  // state   | meaning
  // IDLE    | ready for a block    ARM  | go high, wait w_rdy    REQ     | one-cycle read strobe
  // WAIT    | read latency         OUT  | word offered           RELEASE | go low, wait w_rdy low
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_REQ, S_WAIT, S_OUT, S_RELEASE
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_W - 1);
  localparam logic [7:0] TO_TC    = 8'(TO_MAX - 1);
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [511:0]   r_pad;
  logic [5:0]     r_idx;
  logic [7:0]     r_to_cnt;
  logic [2:0]     r_lat_cnt;
  logic [31:0]    r_w_out;
  logic [5:0]     r_w_idx;
  logic           r_w_last;
  logic           r_to_err;

  logic           w_accept;
  logic           w_to_hit;
  logic           w_capture;
  logic           w_xfer;

  always_comb begin
    w_state_nxt = r_state;
    o_blk_ready = 1'b0;
    o_w_go      = 1'b0;
    o_w_read    = 1'b0;
    o_w_valid   = 1'b0;
    o_done      = 1'b0;
    w_accept    = 1'b0;
    w_to_hit    = 1'b0;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_blk_ready = 1'b1;
        if (i_blk_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        o_w_go = 1'b1;
        if (i_w_rdy) begin
          w_state_nxt = S_REQ;
        end else if (r_to_cnt == TO_TC) begin
          w_to_hit    = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_REQ: begin
        o_w_go      = 1'b1;
        o_w_read    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_w_go = 1'b1;
        if (r_lat_cnt == 3'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        o_w_go    = 1'b1;
        o_w_valid = 1'b1;
        if (i_w_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = r_w_last ? S_RELEASE : S_REQ;
        end
      end
      S_RELEASE: begin
        // a block that timed out in ARM leaves here without a done pulse
        if (!i_w_rdy) begin
          o_done      = !r_to_err;
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == TO_TC) begin
          w_to_hit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pad     <= '0;
      r_idx     <= '0;
      r_to_cnt  <= '0;
      r_lat_cnt <= '0;
      r_w_out   <= '0;
      r_w_idx   <= '0;
      r_w_last  <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pad    <= i_blk_data;
        r_idx    <= '0;
        r_to_err <= 1'b0;
      end
      if (w_to_hit) r_to_err <= 1'b1;
      if (w_state_nxt != r_state) begin
        r_to_cnt <= '0;
      end else if (r_state == S_ARM || r_state == S_RELEASE) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
      if (r_state == S_REQ) begin
        r_lat_cnt <= LAT_INIT;
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 3'd1;
      end
      if (w_capture) begin
        r_w_out  <= i_w_data;
        r_w_idx  <= r_idx;
        r_w_last <= (r_idx == LAST_IDX);
      end
      if (w_xfer && !r_w_last) r_idx <= r_idx + 6'd1;
    end
  end

  assign o_pad_reg     = r_pad;
  assign o_w_addr      = r_idx;
  assign o_w_out       = r_w_out;
  assign o_w_idx       = r_w_idx;
  assign o_w_last      = r_w_last;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout_err = r_to_err;

endmodule

// File: tb/tb_w_sched_ctrl.sv
// Bench for w_sched_ctrl: a generator model computing the SHA-256 schedule from
// pad_reg, a cycle monitor, and directed scenarios with randomized data and handshakes.
module tb_w_sched_ctrl;
  localparam int NUM_W  = 64;
  localparam int RD_LAT = 2;
  localparam int TO_MAX = 255;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         w_rdy;
  logic [31:0]  w_data;
  logic         w_ready;

  logic         o_blk_ready, o_w_go, o_w_read, o_w_valid, o_w_last;
  logic         o_busy, o_done, o_timeout_err;
  logic [511:0] o_pad_reg;
  logic [5:0]   o_w_addr, o_w_idx;
  logic [31:0]  o_w_out;

  int n_pass = 0;
  int n_fail = 0;

  w_sched_ctrl #(.NUM_W(NUM_W), .RD_LAT(RD_LAT), .TO_MAX(TO_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_blk_valid(blk_valid), .o_blk_ready(o_blk_ready), .i_blk_data(blk_data),
    .o_pad_reg(o_pad_reg), .o_w_go(o_w_go), .o_w_read(o_w_read), .o_w_addr(o_w_addr),
    .i_w_rdy(w_rdy), .i_w_data(w_data),
    .o_w_valid(o_w_valid), .i_w_ready(w_ready), .o_w_out(o_w_out), .o_w_idx(o_w_idx),
    .o_w_last(o_w_last), .o_busy(o_busy), .o_done(o_done), .o_timeout_err(o_timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sha_w(input logic [511:0] blk, input int t);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[511 - 32*i -: 32];
      else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
    return w[t];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // generator / round-engine model controls
  bit stuck0 = 1'b0;
  bit rand_ready = 1'b0;
  int stall_idx = -1;
  int stall_left = 0;
  int rdly_up = 0;
  int rdly_dn = 0;
  int rcnt = 0;
  logic [31:0] pend [8];
  bit   [7:0]  pend_v;

  initial begin
    w_rdy = 1'b0; w_ready = 1'b1; w_data = '0; pend_v = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 7; i++) begin
        pend[i] = pend[i+1];
        pend_v[i] = pend_v[i+1];
      end
      pend_v[7] = 1'b0;
      if (!rst_n) begin
        pend_v = '0; rcnt = 0;
        w_rdy = 1'($urandom); w_ready = 1'($urandom); w_data = $urandom;
      end else begin
        if (o_w_read) begin
          pend[RD_LAT] = sha_w(o_pad_reg, int'(o_w_addr));
          pend_v[RD_LAT] = 1'b1;
        end
        w_data = pend_v[0] ? pend[0] : $urandom;
        if (stuck0) w_rdy = 1'b0;
        else if (o_w_go != w_rdy) begin
          if (rcnt >= (o_w_go ? rdly_up : rdly_dn)) begin w_rdy = o_w_go; rcnt = 0; end
          else rcnt++;
        end else rcnt = 0;
        if (o_w_valid && stall_left > 0 && int'(o_w_idx) == stall_idx) begin
          w_ready = 1'b0; stall_left--;
        end else w_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // cycle monitor: expected words come from the block the bench offered
  int cyc = 0, n_acc = 0, acc_cyc = 0, to_cyc = -1;
  int exp_idx = 0, exp_rd = 0, first_rd_addr = -1;
  int blk_xfer = 0, blk_read = 0, blk_last = 0, blk_done = 0;
  int prev_blk_xfer = 0, prev_blk_done = 0;
  int last_xfer_cyc = 0, last_read_cyc = 0;
  bit rel_seen = 1'b0;
  logic [511:0] cur_blk = '0;
  logic [31:0]  exp_w [64];
  logic         prev_valid = 1'b0, prev_stall = 1'b0, prev_busy = 1'b0, prev_w_rdy = 1'b0;
  logic         prev_to = 1'b0, prev_last = 1'b0;
  logic [31:0]  prev_out = '0;
  logic [5:0]   prev_idx = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) cur_blk = '0;
    chk("pad_reg", o_pad_reg, cur_blk);
    if (o_w_read) begin
      if (exp_rd == 0) first_rd_addr = int'(o_w_addr);
      else chk("rd_after_xfer", cyc - last_xfer_cyc, 1);
      chk("rd_addr", o_w_addr, exp_rd);
      exp_rd++; blk_read++; last_read_cyc = cyc;
    end
    if (o_w_valid && !prev_valid) chk("valid_lat", cyc - last_read_cyc, RD_LAT + 1);
    if (prev_stall)
      chk("stall_hold", {o_w_valid, o_w_read, o_w_out, o_w_idx, o_w_last},
          {2'b10, prev_out, prev_idx, prev_last});
    if (o_w_valid && w_ready) begin
      chk("w_out", o_w_out, exp_w[exp_idx & 63]);
      chk("w_idx", o_w_idx, exp_idx);
      chk("w_last", o_w_last, exp_idx == NUM_W - 1);
      exp_idx++; blk_xfer++; last_xfer_cyc = cyc;
      if (o_w_last) blk_last++;
    end
    if (o_done) begin
      blk_done++;
      chk("done_excl_ready", o_blk_ready, 1'b0);
    end
    if (o_busy && !o_w_go) rel_seen = 1'b1;
    if (o_timeout_err && !prev_to) to_cyc = cyc;
    if (rst_n && blk_valid && o_blk_ready) begin
      if (prev_busy) chk("accept_after_rdy_low", prev_w_rdy, 1'b0);
      cur_blk = blk_data;
      for (int i = 0; i < 64; i++) exp_w[i] = sha_w(blk_data, i);
      prev_blk_xfer = blk_xfer; prev_blk_done = blk_done;
      exp_idx = 0; exp_rd = 0; first_rd_addr = -1;
      blk_xfer = 0; blk_read = 0; blk_last = 0; blk_done = 0; rel_seen = 1'b0;
      acc_cyc = cyc; to_cyc = -1; n_acc++;
    end
    prev_valid = o_w_valid; prev_stall = o_w_valid && !w_ready;
    prev_out = o_w_out; prev_idx = o_w_idx; prev_last = o_w_last;
    prev_busy = o_busy; prev_w_rdy = w_rdy; prev_to = o_timeout_err;
  end

  task automatic send_block(input logic [511:0] d);
    int acc0;
    acc0 = n_acc;
    rdly_up = $urandom_range(0, 3);
    rdly_dn = $urandom_range(0, 3);
    blk_valid = 1'b1; blk_data = d;
    for (int k = 0; k < 50 && n_acc == acc0; k++) begin @(posedge clk); #1; end
    blk_valid = 1'b0;
    chk("accept", n_acc - acc0, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && o_busy; k++) begin @(posedge clk); #1; end
    chk("idle_reached", o_busy, 1'b0);
  endtask

  task automatic chk_block(input string tag);
    chk({tag, "_xfers"}, blk_xfer, NUM_W);
    chk({tag, "_reads"}, blk_read, NUM_W);
    chk({tag, "_last"}, blk_last, 1);
    chk({tag, "_done"}, blk_done, 1);
    chk({tag, "_go_fall"}, rel_seen, 1'b1);
  endtask

  initial begin
    int acc0;
    rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0;
    repeat (6) begin
      @(posedge clk); #1;
      blk_valid = 1'($urandom); blk_data = rand512();
      @(negedge clk);
      chk("rst_flags", {o_blk_ready, o_w_go, o_w_read, o_w_valid, o_done, o_timeout_err, o_busy},
          7'b1000000);
      chk("rst_data", {o_w_out, o_w_idx, o_w_addr, o_w_last}, '0);
    end
    @(posedge clk); #1;
    blk_valid = 1'b0; rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // full block, round engine always ready
    rand_ready = 1'b0;
    send_block(rand512());
    wait_idle(2000);
    chk_block("b1");
    chk("b1_to", o_timeout_err, 1'b0);

    // generator never raises w_rdy
    stuck0 = 1'b1;
    send_block(rand512());
    for (int k = 0; k < 400 && to_cyc < 0; k++) begin @(posedge clk); #1; end
    chk("to_cycles", to_cyc - acc_cyc, TO_MAX + 1);
    wait_idle(50);
    chk("to_reads", blk_read, 0);
    chk("to_done", blk_done, 0);
    chk("to_sticky", o_timeout_err, 1'b1);
    stuck0 = 1'b0;
    rand_ready = 1'b1;
    send_block(rand512());
    chk("to_cleared", o_timeout_err, 1'b0);
    wait_idle(2000);
    chk_block("after_to");

    // reset in the middle of a block
    rand_ready = 1'b0;
    send_block(rand512());
    for (int k = 0; k < 1000 && !(o_w_valid && o_w_idx == 6'd30); k++) begin @(posedge clk); #1; end
    chk("mid_reached", {o_w_valid, o_w_idx}, {1'b1, 6'd30});
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_flags", {o_blk_ready, o_w_go, o_w_read, o_w_valid, o_done, o_timeout_err, o_busy},
        7'b1000000);
    chk("mid_rst_data", {o_w_out, o_w_idx, o_w_addr, o_w_last}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {o_w_valid, o_w_read, o_busy}, 3'b000);
    end
    chk("mid_xfers", blk_xfer, 30);
    chk("mid_done", blk_done, 0);

    // restart plus backpressure at idx 10
    @(posedge clk); #1;
    stall_idx = 10; stall_left = 5;
    send_block(rand512());
    wait_idle(2000);
    chk("restart_addr", first_rd_addr, 0);
    chk("bp_stall_used", stall_left, 0);
    chk_block("bp");
    stall_idx = -1;

    // back-to-back with blk_valid held high
    rand_ready = 1'b1;
    acc0 = n_acc;
    blk_valid = 1'b1; blk_data = rand512();
    for (int k = 0; k < 50 && n_acc == acc0; k++) begin @(posedge clk); #1; end
    blk_data = rand512();
    for (int k = 0; k < 3000 && n_acc == acc0 + 1; k++) begin @(posedge clk); #1; end
    blk_valid = 1'b0;
    chk("b2b_accepts", n_acc - acc0, 2);
    chk("b2b_first_xfers", prev_blk_xfer, NUM_W);
    chk("b2b_first_done", prev_blk_done, 1);
    wait_idle(3000);
    chk_block("b2b_second");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
